add_4_nums: RTL and testbench



---
 rtl/add_4_nums_pkg.sv | 17 +
 rtl/add_4_nums_add_pair_reg.sv | 22 ++
 rtl/add_4_nums.sv | 62 ++++++
 tb/tb_add_4_nums.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/add_4_nums_pkg.sv
// Shared sizing for the four-operand adder so integrators derive bus widths
// from the same constants as the RTL.
package add_4_nums_pkg;

  localparam int DATA_W_DEF = 8;

  // Two extra bits hold 4*(2^w-1) without overflow.
  function automatic int sum_width(input int data_w);
    return data_w + 2;
  endfunction

  localparam int SUM_W_DEF = sum_width(DATA_W_DEF);

  typedef logic [DATA_W_DEF-1:0] operand_t;
  typedef logic [SUM_W_DEF-1:0]  sum_t;

endpackage

// File: rtl/add_4_nums_add_pair_reg.sv
// Registered two-operand unsigned adder, N bits in, N+1 bits out.
// Holds its result while i_en is low.
module add_pair_reg #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  output logic [N:0]   o_sum
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum <= '0;
    end else if (i_en) begin
      o_sum <= {1'b0, i_x} + {1'b0, i_y};
    end
  end

endmodule

// File: rtl/add_4_nums.sv
// Two-stage pipelined sum of four unsigned operands. Stage 1 forms pairwise
// sums, stage 2 combines them; o_sum holds its last result between updates.
module add_4_nums
  import add_4_nums_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  localparam int SUM_W  = sum_width(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  input  logic [DATA_W-1:0] i_d,
  output logic [SUM_W-1:0]  o_sum,
  output logic              o_valid
);

  logic [DATA_W:0] p_ab;
  logic [DATA_W:0] p_cd;
  logic            s1_valid;

  add_pair_reg #(.N(DATA_W)) u_pair_ab (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_enable),
    .i_x     (i_a),
    .i_y     (i_b),
    .o_sum   (p_ab)
  );

  add_pair_reg #(.N(DATA_W)) u_pair_cd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_enable),
    .i_x     (i_c),
    .i_y     (i_d),
    .o_sum   (p_cd)
  );

  // Stage 2 only advances when stage 1 captured fresh operands last edge.
  add_pair_reg #(.N(DATA_W + 1)) u_pair_final (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (s1_valid),
    .i_x     (p_ab),
    .i_y     (p_cd),
    .o_sum   (o_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      s1_valid <= i_enable;
      o_valid  <= s1_valid;
    end
  end

endmodule

// File: tb/tb_add_4_nums.sv
// Directed bench for add_4_nums: reset, latency, extremes, streaming,
// enable gating and reset while operands are in flight.
module tb_add_4_nums;

  localparam int DATA_W = 8;
  localparam int SUM_W  = DATA_W + 2;

  logic              r_clk;
  logic              r_rst_n;
  logic              enable;
  logic [DATA_W-1:0] a, b, c, d;
  logic [SUM_W-1:0]  sum;
  logic              valid;

  int n_cmp;
  int n_bad;

  add_4_nums #(.DATA_W(DATA_W)) dut (
    .i_clk    (r_clk),
    .i_rst_n  (r_rst_n),
    .i_enable (enable),
    .i_a      (a),
    .i_b      (b),
    .i_c      (c),
    .i_d      (d),
    .o_sum    (sum),
    .o_valid  (valid)
  );

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic drive(input logic en, input int va, input int vb, input int vc, input int vd);
    enable = en;
    a = DATA_W'(va);
    b = DATA_W'(vb);
    c = DATA_W'(vc);
    d = DATA_W'(vd);
  endtask

  int exp_sum [10];
  int valid_cnt;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    r_rst_n = 1'b0;
    drive(1'b1, 255, 255, 255, 255);

    // reset held across edges with live operands
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_sum", int'(sum), 0);
      chk("rst_valid", int'(valid), 0);
    end

    r_rst_n = 1'b1;
    drive(1'b0, 255, 255, 255, 255);
    tick();
    chk("post_rst_sum", int'(sum), 0);
    chk("post_rst_valid", int'(valid), 0);

    // single sample 1+2+3+4
    drive(1'b1, 1, 2, 3, 4);
    tick();
    drive(1'b0, 0, 0, 0, 0);
    chk("single_lat_sum", int'(sum), 0);
    chk("single_lat_valid", int'(valid), 0);
    tick();
    chk("single_sum", int'(sum), 10);
    chk("single_valid", int'(valid), 1);
    tick();
    chk("single_hold_sum", int'(sum), 10);
    chk("single_hold_valid", int'(valid), 0);

    // extremes
    drive(1'b1, 255, 255, 255, 255);
    tick();
    drive(1'b0, 0, 0, 0, 0);
    tick();
    chk("max_sum", int'(sum), 1020);
    chk("max_valid", int'(valid), 1);
    drive(1'b1, 0, 0, 0, 0);
    tick();
    drive(1'b0, 7, 7, 7, 7);
    tick();
    chk("zero_sum", int'(sum), 0);
    chk("zero_valid", int'(valid), 1);
    tick();

    // streaming: ten back-to-back operand sets
    valid_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        int va, vb, vc, vd;
        va = int'($urandom_range(0, 255));
        vb = int'($urandom_range(0, 255));
        vc = int'($urandom_range(0, 255));
        vd = int'($urandom_range(0, 255));
        exp_sum[i] = va + vb + vc + vd;
        drive(1'b1, va, vb, vc, vd);
      end else begin
        drive(1'b0, 0, 0, 0, 0);
      end
      tick();
      if (valid) valid_cnt++;
      if (i >= 1 && i <= 10) begin
        chk($sformatf("stream_sum[%0d]", i - 1), int'(sum), exp_sum[i-1]);
        chk($sformatf("stream_valid[%0d]", i - 1), int'(valid), 1);
      end else if (i == 11) begin
        chk("stream_end_sum", int'(sum), exp_sum[9]);
        chk("stream_end_valid", int'(valid), 0);
      end else begin
        chk("stream_first_valid", int'(valid), 0);
      end
    end
    chk("stream_valid_cnt", valid_cnt, 10);

    // operands change with enable low
    drive(1'b0, 10, 20, 30, 40);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gate_sum", int'(sum), exp_sum[9]);
      chk("gate_valid", int'(valid), 0);
    end

    // asynchronous reset between edges clears the held result at once
    #2;
    r_rst_n = 1'b0;
    #1;
    chk("async_rst_sum", int'(sum), 0);
    chk("async_rst_valid", int'(valid), 0);
    #1;
    r_rst_n = 1'b1;
    tick();

    // establish a nonzero result, then reset with a sample in flight
    drive(1'b1, 5, 5, 5, 5);
    tick();
    drive(1'b0, 0, 0, 0, 0);
    tick();
    chk("pre_flush_sum", int'(sum), 20);
    drive(1'b1, 100, 100, 100, 100);
    tick();
    drive(1'b0, 0, 0, 0, 0);
    #2;
    r_rst_n = 1'b0;
    #1;
    r_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_sum", int'(sum), 0);
      chk("flush_valid", int'(valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
